// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode, operand forwarding (enabled by ID_EX_FWD_EN) and hazard detection
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [1:0]        InALUOp,
  input  logic [5:0]        InFunct,
  input  logic [4:0]        InShamt,
  input  logic [DATA_W-1:0] InRsData,
  input  logic [DATA_W-1:0] InRtData,
  input  logic [DATA_W-1:0] InImm,
  input  logic [4:0]        InRs,
  input  logic [4:0]        InRt,
  input  logic [4:0]        InRd,
  input  logic [5:0]        InCtrl,
  input  logic              MemRegWrite,
  input  logic [4:0]        MemRd,
  input  logic [DATA_W-1:0] MemResult,
  input  logic              WbRegWrite,
  input  logic [4:0]        WbRd,
  input  logic [DATA_W-1:0] WbResult,
  input  logic [4:0]        IdRs,
  input  logic [4:0]        IdRt,
  output logic              HazardStall,
  output logic [2:0]        Ctl,
  output logic [4:0]        Shamt,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  output logic [DATA_W-1:0] StoreData,
  output logic [4:0]        WriteReg,
  output logic [3:0]        OutCtrl,
  output logic              OutValid
);
  typedef struct packed {
    logic              valid;
    logic              alusrc;
    logic [3:0]        ctrl;
    logic [2:0]        ctl;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        wr;
  } stage_t;
  stage_t r, ld, bub;
  logic [2:0] fn_ctl, dec_ctl;
  logic fn_ok, bad;
  logic [4:0] wr_sel;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic load_use, extra_haz;
  assign fn_ctl = InFunct == 6'b100100 ? 3'b000 :
                  InFunct == 6'b100101 ? 3'b001 :
                  InFunct == 6'b100010 ? 3'b110 :
                  InFunct == 6'b101010 ? 3'b111 :
                  InFunct == 6'b000010 ? 3'b011 : 3'b010;
  assign fn_ok = InFunct inside {6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b000010};
  assign bad = InALUOp == 2'b10 && !fn_ok;
  assign dec_ctl = InALUOp == 2'b00 ? 3'b010 :
                   InALUOp == 2'b01 ? 3'b110 :
                   InALUOp == 2'b11 ? 3'b001 : fn_ctl;
  assign wr_sel = InCtrl[4] ? InRd : InRt;
  always_comb begin
    bub = '0;
    bub.ctl = 3'b010;
  end
  always_comb begin
    ld = bub;
    if (InValid) begin
      ld.valid = 1'b1;
      ld.alusrc = InCtrl[5];
      ld.ctrl = {InCtrl[3] & ~bad & (wr_sel != 5'd0), InCtrl[2] & ~bad, InCtrl[1] & ~bad, InCtrl[0]};
      ld.ctl = dec_ctl;
      ld.shamt = InShamt;
      ld.rs_data = InRsData;
      ld.rt_data = InRtData;
      ld.imm = InImm;
      ld.rs = InRs;
      ld.rt = InRt;
      ld.wr = wr_sel;
    end
  end
  always_ff @(posedge clk)
    if (rst || Flush) r <= bub;
    else if (!Stall) r <= ld;
`ifdef ID_EX_FWD_EN
  logic mem_a, mem_b, wb_a, wb_b;
  assign mem_a = MemRegWrite && MemRd != 5'd0 && MemRd == r.rs;
  assign mem_b = MemRegWrite && MemRd != 5'd0 && MemRd == r.rt;
  assign wb_a = WbRegWrite && WbRd != 5'd0 && WbRd == r.rs;
  assign wb_b = WbRegWrite && WbRd != 5'd0 && WbRd == r.rt;
  assign fwd_a = mem_a ? MemResult : wb_a ? WbResult : r.rs_data;
  assign fwd_b = mem_b ? MemResult : wb_b ? WbResult : r.rt_data;
  assign extra_haz = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{WbRegWrite, WbRd, WbResult, MemResult, r.rs, r.rt};
  assign fwd_a = r.rs_data;
  assign fwd_b = r.rt_data;
  // without forwarding any in-flight writer of an ID source must stall ID
  assign extra_haz = (r.valid && r.ctrl[3] && ((IdRs != 5'd0 && r.wr == IdRs) || (IdRt != 5'd0 && r.wr == IdRt))) ||
                     (MemRegWrite && ((IdRs != 5'd0 && MemRd == IdRs) || (IdRt != 5'd0 && MemRd == IdRt)));
`endif
  assign load_use = r.valid && r.ctrl[2] && r.wr != 5'd0 && (r.wr == IdRs || r.wr == IdRt);
  assign HazardStall = load_use || extra_haz;
  assign Ctl = r.ctl;
  assign Shamt = r.shamt;
  assign DataA = fwd_a;
  assign DataB = r.alusrc ? r.imm : fwd_b;
  assign StoreData = fwd_b;
  assign WriteReg = r.wr;
  assign OutCtrl = r.ctrl;
  assign OutValid = r.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, Stall, Flush, InValid;
  logic [1:0] InALUOp;
  logic [5:0] InFunct, InCtrl;
  logic [4:0] InShamt, InRs, InRt, InRd, MemRd, WbRd, IdRs, IdRt;
  logic [31:0] InRsData, InRtData, InImm, MemResult, WbResult;
  logic MemRegWrite, WbRegWrite;
  logic HazardStall, OutValid;
  logic [2:0] Ctl;
  logic [4:0] Shamt, WriteReg;
  logic [31:0] DataA, DataB, StoreData;
  logic [3:0] OutCtrl;
  int total = 0;
  int bad = 0;
  id_ex_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .InALUOp(InALUOp), .InFunct(InFunct), .InShamt(InShamt),
    .InRsData(InRsData), .InRtData(InRtData), .InImm(InImm),
    .InRs(InRs), .InRt(InRt), .InRd(InRd), .InCtrl(InCtrl),
    .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemResult(MemResult),
    .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbResult(WbResult),
    .IdRs(IdRs), .IdRt(IdRt), .HazardStall(HazardStall),
    .Ctl(Ctl), .Shamt(Shamt), .DataA(DataA), .DataB(DataB), .StoreData(StoreData),
    .WriteReg(WriteReg), .OutCtrl(OutCtrl), .OutValid(OutValid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    rst = 0; Stall = 0; Flush = 0; InValid = 0; InALUOp = 0; InFunct = 0; InShamt = 0;
    InRsData = 0; InRtData = 0; InImm = 0; InRs = 0; InRt = 0; InRd = 0; InCtrl = 0;
    MemRegWrite = 0; MemRd = 0; MemResult = 0; WbRegWrite = 0; WbRd = 0; WbResult = 0;
    IdRs = 0; IdRt = 0;
  endtask
  initial begin
    idle();
    rst = 1; InValid = 1; InCtrl = 6'h3F; InRsData = 32'h55; InRd = 5'd7; InALUOp = 2'b01;
    tick();
    chk("rst_valid", OutValid, 0);
    chk("rst_ctrl", OutCtrl, 0);
    chk("rst_ctl", Ctl, 3'b010);
    chk("rst_wr", WriteReg, 0);
    chk("rst_a", DataA, 0);
    chk("rst_b", DataB, 0);
    chk("rst_sd", StoreData, 0);
    chk("rst_haz", HazardStall, 0);
    idle();
    InValid = 1; InALUOp = 2'b10; InFunct = 6'b101010; InRsData = 5; InRtData = 9;
    InRs = 1; InRt = 2; InRd = 8; InCtrl = 6'b011000;
    tick();
    chk("slt_ctl", Ctl, 3'b111);
    chk("slt_wr", WriteReg, 8);
    chk("slt_a", DataA, 5);
    chk("slt_b", DataB, 9);
    chk("slt_ctrl", OutCtrl, 4'b1000);
    chk("slt_valid", OutValid, 1);
    Stall = 1; InRsData = 77; InFunct = 6'b100000; InRd = 3;
    tick();
    chk("stall_ctl", Ctl, 3'b111);
    chk("stall_a", DataA, 5);
    chk("stall_wr", WriteReg, 8);
    chk("stall_valid", OutValid, 1);
    Flush = 1;
    tick();
    chk("flush_valid", OutValid, 0);
    chk("flush_ctl", Ctl, 3'b010);
    chk("flush_wr", WriteReg, 0);
    idle();
    InValid = 1; InRs = 3; InRt = 5; InRd = 6; InRsData = 32'h11; InRtData = 32'h22; InCtrl = 6'b011000;
    tick();
    idle();
    MemRegWrite = 1; MemRd = 3; MemResult = 32'hAA; WbRegWrite = 1; WbRd = 3; WbResult = 32'hBB;
    #1;
    chk("fwd_mem_a", DataA, FWD ? 32'hAA : 32'h11);
    chk("fwd_b_nomatch", DataB, 32'h22);
    MemRegWrite = 0;
    #1;
    chk("fwd_wb_a", DataA, FWD ? 32'hBB : 32'h11);
    MemRegWrite = 1; MemRd = 5;
    #1;
    chk("fwd_mem_sd", StoreData, FWD ? 32'hAA : 32'h22);
    chk("fwd_wb_a2", DataA, FWD ? 32'hBB : 32'h11);
    chk("fwd_haz", HazardStall, 0);
    idle();
    InValid = 1; InRs = 0; InRt = 5; InRsData = 32'h33; InRtData = 32'h22; InImm = 32'h1234; InCtrl = 6'b101000;
    tick();
    idle();
    MemRegWrite = 1; MemRd = 0; MemResult = 32'hAA; WbRegWrite = 1; WbRd = 0; WbResult = 32'hBB;
    #1;
    chk("rs0_a", DataA, 32'h33);
    chk("imm_b", DataB, 32'h1234);
    chk("imm_sd", StoreData, 32'h22);
    chk("imm_wr", WriteReg, 5);
    idle();
    InValid = 1; InRt = 4; InCtrl = 6'b101101; InImm = 8;
    tick();
    idle();
    IdRt = 4;
    #1;
    chk("lu_haz", HazardStall, 1);
    IdRt = 0;
    #1;
    chk("lu_nohaz", HazardStall, 0);
    InValid = 1; InRt = 0; InCtrl = 6'b101101;
    tick();
    idle();
    chk("lw0_ctrl", OutCtrl, 4'b0101);
    chk("lw0_wr", WriteReg, 0);
    chk("lw0_haz", HazardStall, 0);
    InValid = 1; InALUOp = 2'b10; InFunct = 6'b000010; InShamt = 7; InRd = 9; InCtrl = 6'b011000;
    tick();
    chk("srl_ctl", Ctl, 3'b011);
    chk("srl_shamt", Shamt, 7);
    chk("srl_ctrl", OutCtrl, 4'b1000);
    idle();
    IdRs = 9;
    #1;
    chk("raw_ex_haz", HazardStall, FWD ? 1'b0 : 1'b1);
    IdRs = 0; IdRt = 7; MemRegWrite = 1; MemRd = 7;
    #1;
    chk("raw_mem_haz", HazardStall, FWD ? 1'b0 : 1'b1);
    idle();
    InValid = 1; InALUOp = 2'b10; InFunct = 6'b000000; InShamt = 7; InRd = 9; InCtrl = 6'b011110;
    tick();
    chk("badfn_ctl", Ctl, 3'b010);
    chk("badfn_ctrl", OutCtrl, 4'b0000);
    InFunct = 6'b100100;
    tick();
    chk("and_ctl", Ctl, 3'b000);
    InFunct = 6'b100101;
    tick();
    chk("or_fn_ctl", Ctl, 3'b001);
    InFunct = 6'b100010;
    tick();
    chk("sub_fn_ctl", Ctl, 3'b110);
    InALUOp = 2'b01;
    tick();
    chk("sub_ctl", Ctl, 3'b110);
    InALUOp = 2'b11;
    tick();
    chk("ori_ctl", Ctl, 3'b001);
    InALUOp = 2'b00; InValid = 0;
    tick();
    chk("inv_valid", OutValid, 0);
    chk("inv_wr", WriteReg, 0);
    chk("inv_shamt", Shamt, 0);
    InValid = 1;
    tick();
    chk("reload_valid", OutValid, 1);
    rst = 1; Stall = 1;
    tick();
    chk("rst_over_stall", OutValid, 0);
    chk("rst_over_ctl", Ctl, 3'b010);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width of all operand and result buses.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Stall  in  1  hold all stage registers.
REQ-005 Flush  in  1  load a bubble into the stage.
REQ-006 InValid  in  1  ID-stage instruction valid.
REQ-007 InALUOp  in  2  00 add, 01 sub, 10 R-type by funct, 11 or.
REQ-008 InFunct  in  6  R-type funct field.
REQ-009 InShamt  in  5  shift amount field.
REQ-010 InRsData, InRtData, InImm  in  DATA_W each  register-file reads and sign-extended immediate.
REQ-011 InRs, InRt, InRd  in  5 each  register indices.
REQ-012 InCtrl  in  6  {ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg}.
REQ-013 MemRegWrite (1), MemRd (5), MemResult (DATA_W)  in  EX/MEM forwarding source.
REQ-014 WbRegWrite (1), WbRd (5), WbResult (DATA_W)  in  MEM/WB forwarding source.
REQ-015 IdRs, IdRt  in  5 each  source indices of the instruction currently in ID.
REQ-016 HazardStall  out  1  load-use hazard detected.
REQ-017 Ctl  out  3, Shamt  out  5  ALU operation code and shift amount.
REQ-018 DataA, DataB, StoreData  out  DATA_W each  ALU operands and store data.
REQ-019 WriteReg  out  5; OutCtrl  out  4 {RegWrite, MemRead, MemWrite, MemtoReg}; OutValid  out  1.

Function
REQ-020 Register update priority at each rising edge SHALL be rst > Flush > Stall > load.
REQ-021 Load SHALL capture all In* fields with 1-cycle latency and set WriteReg = RegDst ? InRd : InRt.
REQ-022 Ctl decode at load: ALUOp 00->010, 01->110, 11->001; ALUOp 10 by funct: 100100->000, 100101->001, 100000->010, 100010->110, 101010->111, 000010->011.
REQ-023 ALUOp 10 with any other funct SHALL give Ctl 010 and clear captured RegWrite, MemRead and MemWrite.
REQ-024 Captured RegWrite SHALL be 0 when WriteReg is 0; InValid=0 on load SHALL capture a bubble.
REQ-025 Bubble SHALL be: OutValid 0, OutCtrl 0, WriteReg 0, Ctl 010, Shamt 0, all stored data and indices 0.
REQ-026 Stall without Flush SHALL hold every register; combinational outputs still track forwarding inputs.
REQ-027 fwdA SHALL be MemResult if MemRegWrite, MemRd!=0 and MemRd==stored Rs; else WbResult on the same test with Wb*; else stored RsData. fwdB uses stored Rt in the same way.
REQ-028 EX/MEM match SHALL win over MEM/WB match.
REQ-029 DataA = fwdA; DataB = ALUSrc ? stored Imm : fwdB; StoreData = fwdB regardless of ALUSrc.
REQ-030 HazardStall = OutValid and captured MemRead and WriteReg!=0 and (WriteReg==IdRs or WriteReg==IdRt). It is combinational, and the stage takes no action on it.

Reset
REQ-031 rst high at an edge SHALL load the bubble of REQ-025, overriding Flush and Stall.
REQ-032 After reset with no forwarding match, DataA, DataB and StoreData SHALL read 0 and HazardStall 0.

Configuration
REQ-033 Macro ID_EX_FWD_EN defined: forwarding per REQ-027/028.
REQ-034 ID_EX_FWD_EN undefined: fwdA = stored RsData and fwdB = stored RtData; Mem*/Wb* forwarding ports are ignored.
REQ-035 ID_EX_FWD_EN undefined: HazardStall additionally asserts when (OutValid, captured RegWrite, WriteReg matches nonzero IdRs or IdRt) or (MemRegWrite, MemRd matches nonzero IdRs or IdRt).

Verification
REQ-036 Reset: rst=1 for one edge with InCtrl=6'h3F, InValid=1 -> OutValid 0, OutCtrl 0, Ctl 010, DataA 0, HazardStall 0.
REQ-037 slt: ALUOp 10, funct 101010, RsData 5, RtData 9, Rd 8, RegDst 1, RegWrite 1 -> next cycle Ctl 111, WriteReg 8, DataA 5, DataB 9.
REQ-038 Forwarding: stored Rs 3, MemRd 3 with MemResult 0xAA, WbRd 3 with WbResult 0xBB, both RegWrite -> DataA 0xAA; MemRegWrite 0 -> 0xBB; Rs 0 -> stored RsData.
REQ-039 Load-use: EX holds lw with WriteReg 4, IdRt 4 -> HazardStall 1; WriteReg 0 -> 0.
REQ-040 Stall and Flush both high -> OutValid 0; Stall alone with changed inputs -> registered outputs unchanged.
REQ-041 ALUOp 10, funct 000010, shamt 7 -> Ctl 011, Shamt 7; funct 000000 -> Ctl 010, OutCtrl RegWrite 0.
